// File: rtl/alu_shift_pkg.sv
// ============================================================================
// Module      : alu_shift_pkg
// Description : Operation and shift-mode encodings for alu_shift_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_shift_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOTA  = 3'b101;
  localparam logic [2:0] OP_INC   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Only the adder-based ops produce meaningful carry and overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_barrel_shift.sv
// ============================================================================
// Module      : alu_barrel_shift
// Description : Combinational barrel shifter with saturating oversize amounts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_barrel_shift
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] dout
);

  logic w_oversize;

  assign w_oversize = (shamt >= SHW'(WIDTH));

  always_comb begin
    dout = din;
    case (mode)
      SH_LSL:  dout = w_oversize ? '0 : (din << shamt);
      SH_LSR:  dout = w_oversize ? '0 : (din >> shamt);
      SH_ASR:  dout = w_oversize ? {WIDTH{din[WIDTH-1]}}
                                 : WIDTH'($signed(din) >>> shamt);
      default: dout = din;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_shift_pipe.sv
// ============================================================================
// Module      : alu_shift_pipe
// Description : Two-stage valid/ready pipeline: ALU in stage 1, shifter in 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shift_pipe
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic [1:0]       shmode,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  logic             w_s1_en;
  logic             w_s2_en;
  logic [WIDTH-1:0] w_bop;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_arith;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_shifted;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_res;
  logic             r_s1_cout;
  logic             r_s1_ovf;
  logic [1:0]       r_s1_mode;
  logic [SHW-1:0]   r_s1_shamt;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  // A stage may load when empty or when its current content leaves this cycle.
  assign w_s2_en  = !r_s2_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  always_comb begin
    w_bop = b;
    w_cin = cin;
    case (op)
      OP_SUB:  w_bop = ~b;
      OP_INC: begin
        w_bop = WIDTH'(1);
        w_cin = 1'b0;
      end
      default: w_bop = b;
    endcase
  end

  assign w_sum   = {1'b0, a} + {1'b0, w_bop} + (WIDTH+1)'(w_cin);
  assign w_arith = is_arith(op);

  always_comb begin
    w_alu_res = w_sum[WIDTH-1:0];
    case (op)
      OP_AND:   w_alu_res = a & b;
      OP_OR:    w_alu_res = a | b;
      OP_XOR:   w_alu_res = a ^ b;
      OP_NOTA:  w_alu_res = ~a;
      OP_PASSB: w_alu_res = b;
      default:  w_alu_res = w_sum[WIDTH-1:0];
    endcase
  end

  assign w_cout = w_arith && w_sum[WIDTH];
  assign w_ovf  = w_arith && (a[WIDTH-1] == w_bop[WIDTH-1])
                          && (w_sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_res   <= '0;
      r_s1_cout  <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_mode  <= SH_NONE;
      r_s1_shamt <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_res   <= w_alu_res;
        r_s1_cout  <= w_cout;
        r_s1_ovf   <= w_ovf;
        r_s1_mode  <= shmode;
        r_s1_shamt <= shamt;
      end
    end
  end

  alu_barrel_shift #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .din   (r_s1_res),
    .mode  (r_s1_mode),
    .shamt (r_s1_shamt),
    .dout  (w_shifted)
  );

  // Output registers only update on a real beat so they hold during stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_shifted;
        r_cout   <= r_s1_cout;
        r_ovf    <= r_s1_ovf;
        r_zero   <= (w_shifted == '0);
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_pipe.sv
// ============================================================================
// Module      : tb_alu_shift_pipe
// Description : Directed and model-checked bench for alu_shift_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_shift_pipe;
  import alu_shift_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8 instance
  logic       in_valid, in_ready, out_valid, out_ready, cin, cout, ovf, zero;
  logic [7:0] a, b, result;
  logic [2:0] op;
  logic [1:0] shmode;
  logic [3:0] shamt;

  alu_shift_pipe #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .shmode(shmode), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  // WIDTH=4 instance
  logic       iv4, ir4, ov4, cin4, co4, of4, z4;
  logic [3:0] a4, b4, r4;
  logic [2:0] op4, sa4;
  logic [1:0] sm4;

  alu_shift_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .op(op4), .cin(cin4), .shmode(sm4), .shamt(sa4),
    .out_valid(ov4), .out_ready(1'b1), .result(r4),
    .cout(co4), .ovf(of4), .zero(z4)
  );

  // WIDTH=16 instance
  logic        iv16, ir16, ov16, cin16, co16, of16, z16;
  logic [15:0] a16, b16, r16;
  logic [2:0]  op16;
  logic [4:0]  sa16;
  logic [1:0]  sm16;

  alu_shift_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .op(op16), .cin(cin16), .shmode(sm16), .shamt(sa16),
    .out_valid(ov16), .out_ready(1'b1), .result(r16),
    .cout(co16), .ovf(of16), .zero(z16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {cout, ovf, zero, result[15:0]} for width w.
  function automatic logic [18:0] model(input int w, input logic [15:0] ai, input logic [15:0] bi,
                                        input logic [2:0] opi, input logic ci,
                                        input logic [1:0] shm, input int sa);
    logic [16:0] mask, aa, bb, bo, s, r;
    logic co, ov, sign;
    mask = (17'd1 << w) - 17'd1;
    aa = {1'b0, ai} & mask;
    bb = {1'b0, bi} & mask;
    co = 1'b0; ov = 1'b0; bo = 17'd0; r = 17'd0;
    if (opi == OP_ADD || opi == OP_SUB || opi == OP_INC) begin
      if (opi == OP_ADD)      begin bo = bb;          s = aa + bo + 17'(ci); end
      else if (opi == OP_SUB) begin bo = ~bb & mask;  s = aa + bo + 17'(ci); end
      else                    begin bo = 17'd1;       s = aa + bo;           end
      r  = s & mask;
      co = s[w];
      ov = (aa[w-1] == bo[w-1]) && (r[w-1] != aa[w-1]);
    end else begin
      case (opi)
        OP_AND:  r = aa & bb;
        OP_OR:   r = aa | bb;
        OP_XOR:  r = aa ^ bb;
        OP_NOTA: r = ~aa & mask;
        default: r = bb;
      endcase
    end
    sign = r[w-1];
    case (shm)
      SH_LSL:  r = (sa >= w) ? 17'd0 : ((r << sa) & mask);
      SH_LSR:  r = (sa >= w) ? 17'd0 : (r >> sa);
      SH_ASR:  r = (sa >= w) ? (sign ? mask : 17'd0)
                             : ((r >> sa) | (sign ? (mask & ~(mask >> sa)) : 17'd0));
      default: r = r;
    endcase
    return {co, ov, (r == 17'd0), r[15:0]};
  endfunction

  // Single beat on the WIDTH=8 instance; starts and ends at a negedge.
  task automatic send_one(input string tag, input logic [2:0] o, input logic [7:0] av,
                          input logic [7:0] bv, input logic c, input logic [1:0] m,
                          input logic [3:0] s, input logic [7:0] er, input logic ec,
                          input logic eo, input logic ez);
    op = o; a = av; b = bv; cin = c; shmode = m; shamt = s;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid, 0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_valid"},  out_valid, 1);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"},   cout, ec);
    chk({tag, "_ovf"},    ovf, eo);
    chk({tag, "_zero"},   zero, ez);
    @(posedge clk); @(negedge clk);
  endtask

  logic [7:0]  sa_t [6] = '{8'h10, 8'h80, 8'h3C, 8'h7F, 8'hA5, 8'h00};
  logic [7:0]  sb_t [6] = '{8'h20, 8'h01, 8'hFF, 8'h00, 8'h0F, 8'h90};
  logic [2:0]  op_t [6] = '{OP_ADD, OP_SUB, OP_XOR, OP_INC, OP_OR, OP_PASSB};
  logic [1:0]  sm_t [6] = '{SH_NONE, SH_LSL, SH_LSR, SH_ASR, SH_LSL, SH_ASR};
  logic [3:0]  am_t [6] = '{4'd0, 4'd2, 4'd1, 4'd3, 4'd8, 4'd15};
  logic        pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [18:0] q [$];

  initial begin
    int sent, got, occ, cyc;
    logic pv, pr;
    logic [18:0] hold, exp;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; cin = 1'b0; shmode = '0; shamt = '0;
    iv4 = 1'b0; a4 = '0; b4 = '0; op4 = '0; cin4 = 1'b0; sm4 = '0; sa4 = '0;
    iv16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; cin16 = 1'b0; sm16 = '0; sa16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result",    result, 0);
    chk("rst_cout",      cout, 0);
    chk("rst_ovf",       ovf, 0);
    chk("rst_zero",      zero, 0);
    chk("rst_in_ready",  in_ready, 1);
    reset = 1'b0;

    send_one("add_ovf",  OP_ADD,   8'h7F, 8'h01, 1'b0, SH_NONE, 4'd0, 8'h80, 1'b0, 1'b1, 1'b0);
    send_one("sub_zero", OP_SUB,   8'h05, 8'h05, 1'b1, SH_LSL,  4'd3, 8'h00, 1'b1, 1'b0, 1'b1);
    send_one("asr2",     OP_PASSB, 8'h00, 8'h90, 1'b0, SH_ASR,  4'd2, 8'hE4, 1'b0, 1'b0, 1'b0);
    send_one("asr9",     OP_PASSB, 8'h00, 8'h90, 1'b0, SH_ASR,  4'd9, 8'hFF, 1'b0, 1'b0, 1'b0);
    send_one("lsr9",     OP_PASSB, 8'h00, 8'h90, 1'b0, SH_LSR,  4'd9, 8'h00, 1'b0, 1'b0, 1'b1);

    // Backpressure stream: 6 beats with out_ready following a fixed pattern.
    sent = 0; got = 0; occ = 0; cyc = 0; pv = 1'b0; pr = 1'b1; hold = '0;
    while (got < 6 && cyc < 60) begin
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {cout, ovf, zero, 8'h00, result}, hold);
      end
      out_ready = pat[cyc % 6];
      in_valid  = (sent < 6);
      if (sent < 6) begin
        a = sa_t[sent]; b = sb_t[sent]; op = op_t[sent]; cin = sent[0];
        shmode = sm_t[sent]; shamt = am_t[sent];
      end
      #1;
      chk("stall_in_ready", in_ready, !(occ == 2 && !out_ready));
      if (out_valid && out_ready) begin
        exp = (q.size() > 0) ? q.pop_front() : 19'h7FFFF;
        chk("stall_data", {cout, ovf, zero, 8'h00, result}, exp);
        got++; occ--;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(8, {8'h00, a}, {8'h00, b}, op, cin, shmode, int'(shamt)));
        sent++; occ++;
      end
      pv = out_valid; pr = out_ready;
      hold = {cout, ovf, zero, 8'h00, result};
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_count", got, 6);
    chk("stall_queue_empty", q.size(), 0);
    @(posedge clk); @(negedge clk);

    // Mid-stream reset with two beats held in the pipeline.
    out_ready = 1'b0;
    op = OP_ADD; a = 8'h01; b = 8'h02; cin = 1'b0; shmode = SH_NONE; shamt = '0;
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 8'h03;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_full", {out_valid, in_ready}, 2'b10);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result",    result, 0);
    chk("midrst_in_ready",  in_ready, 1);
    @(posedge clk); @(negedge clk);
    chk("midrst_no_ghost", out_valid, 0);
    send_one("inc_wrap", OP_INC, 8'hFF, 8'h00, 1'b1, SH_NONE, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1);

    // WIDTH=4 random stream at full throughput.
    q.delete();
    for (int i = 0; i < 204; i++) begin
      if (ov4) begin
        exp = (q.size() > 0) ? q.pop_front() : 19'h7FFFF;
        chk("w4_data", {co4, of4, z4, 12'h000, r4}, exp);
      end
      iv4 = (i < 200);
      a4 = 4'($urandom); b4 = 4'($urandom); op4 = 3'($urandom); cin4 = 1'($urandom);
      sm4 = 2'($urandom); sa4 = 3'($urandom);
      #1;
      if (iv4 && ir4) q.push_back(model(4, {12'h000, a4}, {12'h000, b4}, op4, cin4, sm4, int'(sa4)));
      @(posedge clk); @(negedge clk);
    end
    iv4 = 1'b0;
    chk("w4_queue_empty", q.size(), 0);

    // WIDTH=16 random stream at full throughput.
    q.delete();
    for (int i = 0; i < 204; i++) begin
      if (ov16) begin
        exp = (q.size() > 0) ? q.pop_front() : 19'h7FFFF;
        chk("w16_data", {co16, of16, z16, r16}, exp);
      end
      iv16 = (i < 200);
      a16 = 16'($urandom); b16 = 16'($urandom); op16 = 3'($urandom); cin16 = 1'($urandom);
      sm16 = 2'($urandom); sa16 = 5'($urandom);
      if ((i % 7) == 3) b16 = ~a16;
      #1;
      if (iv16 && ir16) q.push_back(model(16, a16, b16, op16, cin16, sm16, int'(sa16)));
      @(posedge clk); @(negedge clk);
    end
    iv16 = 1'b0;
    chk("w16_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
